// File: rtl/wbu_buf_if.sv
// Handshake and data bundle between memory stage, write-back buffer
// and the register-file write port.
interface wbu_buf_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rd_i;
  logic [XLEN-1:0]   alu_out;
  logic [XLEN-1:0]   load_out;
  logic [1:0]        addr_lo;
  logic              wb_ready;
  logic              wr_en;
  logic [REG_AW-1:0] rd_o;
  logic [XLEN-1:0]   rd_data;
  logic [CW-1:0]     count;

  modport master (
    output in_valid, opcode, funct3, rd_i,
    output alu_out, load_out, addr_lo, wb_ready,
    input  in_ready, wr_en, rd_o, rd_data, count
  );

  modport slave (
    input  in_valid, opcode, funct3, rd_i,
    input  alu_out, load_out, addr_lo, wb_ready,
    output in_ready, wr_en, rd_o, rd_data, count
  );
endinterface

// File: rtl/wbu_buf.sv
// Write-back unit: load formatting plus an in-order buffer to the RF port.
// Optional retire counter enabled by defining WBU_RETIRE_CNT_EN.
`ifndef opcode_R
`define opcode_R       7'b0110011
`endif
`ifndef opcode_I_lg
`define opcode_I_lg    7'b0010011
`endif
`ifndef opcode_I_ld
`define opcode_I_ld    7'b0000011
`endif
`ifndef opcode_U_lui
`define opcode_U_lui   7'b0110111
`endif
`ifndef opcode_U_auipc
`define opcode_U_auipc 7'b0010111
`endif
`ifndef opcode_J_jal
`define opcode_J_jal   7'b1101111
`endif
`ifndef opcode_J_jalr
`define opcode_J_jalr  7'b1100111
`endif

module wbu_buf #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef WBU_RETIRE_CNT_EN
  input  logic        retire_clr,
  output logic [63:0] retire_cnt,
`endif
  wbu_buf_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] head;

  logic            wr_op;
  logic            is_ld;
  logic            accept;
  logic            push;
  logic            pop;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_fmt;
  entry_t          in_e;

  always_comb begin
    wr_op = 1'b0;
    unique case (1'b1)
      bus.opcode == `opcode_R,
      bus.opcode == `opcode_I_lg,
      bus.opcode == `opcode_I_ld,
      bus.opcode == `opcode_U_lui,
      bus.opcode == `opcode_U_auipc,
      bus.opcode == `opcode_J_jal,
      bus.opcode == `opcode_J_jalr: wr_op = 1'b1;
      default: wr_op = 1'b0;
    endcase
  end

  assign is_ld = (bus.opcode == `opcode_I_ld);
  assign ld_b  = bus.load_out[{bus.addr_lo, 3'b000} +: 8];
  assign ld_h  = bus.load_out[{bus.addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_fmt = bus.load_out;
    unique case (bus.funct3)
      3'b000:  ld_fmt = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_b};
      3'b001:  ld_fmt = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_fmt = bus.load_out;
    endcase
  end

  assign in_e.rd   = bus.rd_i;
  assign in_e.data = is_ld ? ld_fmt : bus.alu_out;

  assign pop    = (cnt_q != '0) && bus.wb_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && wr_op && (bus.rd_i != '0);

  assign bus.in_ready = (cnt_q < CW'(DEPTH)) || pop;

  // when empty, show the slot just behind rptr: the last entry written out
  assign head        = (cnt_q != '0) ? rptr_q : rptr_q - AW'(1);
  assign bus.wr_en   = (cnt_q != '0);
  assign bus.rd_o    = mem_q[head].rd;
  assign bus.rd_data = mem_q[head].data;
  assign bus.count   = cnt_q;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push) wptr_d = wptr_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      if (push) mem_q[wptr_q] <= in_e;
    end
  end

`ifdef WBU_RETIRE_CNT_EN
  logic [63:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q + 64'(accept);
    if (retire_clr) rcnt_d = 64'(accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end

  assign retire_cnt = rcnt_q;
`endif
endmodule

// File: tb/tb_wbu_buf.sv
// Directed plus random bench for wbu_buf against a queue-based model.
// Define WBU_RETIRE_CNT_EN to also check the retire counter.
module tb_wbu_buf;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LG  = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wbu_buf_if #(.XLEN(32), .REG_AW(5), .DEPTH(4)) bus ();

`ifdef WBU_RETIRE_CNT_EN
  logic        retire_clr = 1'b0;
  logic [63:0] retire_cnt;
  longint unsigned m_rc = 0;
  wbu_buf #(.XLEN(32), .REG_AW(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .retire_clr(retire_clr), .retire_cnt(retire_cnt),
    .bus(bus)
  );
`else
  wbu_buf #(.XLEN(32), .REG_AW(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  int unsigned q_rd[$];
  int unsigned q_dat[$];
  int unsigned last_rd = 0;
  int unsigned last_dat = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned fmt(input int unsigned f3,
                                      input int unsigned ld,
                                      input int unsigned a);
    int unsigned b, h;
    b = (ld >> (8 * a)) % 256;
    h = (ld >> (16 * (a / 2))) % 65536;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      default: return ld;
    endcase
  endfunction

  function automatic bit writes(input logic [6:0] op);
    return op == OP_R || op == OP_LG || op == OP_LD ||
           op == OP_LUI || op == OP_AUI ||
           op == OP_JAL || op == OP_JR;
  endfunction

  task automatic check_outs(input string tag);
    bit ne;
    ne = q_rd.size() != 0;
    chk({tag, ".wr_en"}, 64'(bus.wr_en), 64'(ne));
    chk({tag, ".count"}, 64'(bus.count), 64'(q_rd.size()));
    chk({tag, ".rd_o"}, 64'(bus.rd_o), 64'(ne ? q_rd[0] : last_rd));
    chk({tag, ".rd_data"}, 64'(bus.rd_data),
        64'(ne ? q_dat[0] : last_dat));
`ifdef WBU_RETIRE_CNT_EN
    chk({tag, ".retire"}, retire_cnt, m_rc);
`endif
  endtask

  task automatic cyc(input string tag, input logic v,
                     input logic [6:0] op, input logic [2:0] f3,
                     input logic [4:0] rd, input logic [31:0] alu,
                     input logic [31:0] ld, input logic [1:0] a,
                     input logic wr);
    bit exp_rdy, acc, pop;
    bus.in_valid = v;
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.rd_i     = rd;
    bus.alu_out  = alu;
    bus.load_out = ld;
    bus.addr_lo  = a;
    bus.wb_ready = wr;
    #1;
    pop = q_rd.size() != 0 && wr;
    exp_rdy = q_rd.size() < 4 || pop;
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    if (pop) begin
      last_rd  = q_rd.pop_front();
      last_dat = q_dat.pop_front();
    end
    if (acc && writes(op) && rd != 0) begin
      q_rd.push_back(rd);
      q_dat.push_back(op == OP_LD ? fmt(f3, ld, a) : alu);
    end
`ifdef WBU_RETIRE_CNT_EN
    m_rc = retire_clr ? 64'(acc) : m_rc + 64'(acc);
`endif
    #1;
    check_outs(tag);
  endtask

  task automatic idle(input string tag, input logic wr);
    cyc(tag, 1'b0, OP_R, 3'd0, 5'd0, 32'd0, 32'd0, 2'd0, wr);
  endtask

  initial begin
    logic [6:0] ops [9];
    ops = '{OP_R, OP_LG, OP_LD, OP_LUI, OP_AUI,
            OP_JAL, OP_JR, OP_ST, OP_BR};
    bus.in_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0;
    bus.rd_i = '0; bus.alu_out = '0; bus.load_out = '0;
    bus.addr_lo = '0; bus.wb_ready = 1'b0;
    #12;
    check_outs("reset");
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    cyc("lb3", 1, OP_LD, 3'b000, 5'd1, 32'd0, 32'h80FF7F01, 2'd3, 1);
    chk("lb3.val", 64'(bus.rd_data), 64'hFFFF_FF80);
    cyc("lb1", 1, OP_LD, 3'b000, 5'd2, 32'd0, 32'h80FF7F01, 2'd1, 1);
    chk("lb1.val", 64'(bus.rd_data), 64'h0000_007F);
    cyc("lhu2", 1, OP_LD, 3'b101, 5'd3, 32'd0, 32'h80FF7F01, 2'd2, 1);
    chk("lhu2.val", 64'(bus.rd_data), 64'h0000_80FF);
    cyc("lw", 1, OP_LD, 3'b010, 5'd4, 32'd0, 32'h80FF7F01, 2'd0, 1);
    chk("lw.val", 64'(bus.rd_data), 64'h80FF_7F01);
    idle("drain", 1);

    cyc("drop.st", 1, OP_ST, 3'd2, 5'd5, 32'h55, 32'd0, 2'd0, 1);
    chk("drop.st.cnt", 64'(bus.count), 64'd0);
    cyc("drop.r0", 1, OP_R, 3'd0, 5'd0, 32'h66, 32'd0, 2'd0, 1);
    chk("drop.r0.wr", 64'(bus.wr_en), 64'd0);

    for (int i = 1; i <= 4; i++)
      cyc("bp.push", 1, OP_R, 3'd0, 5'(i), 32'(i * 16), 32'd0, 2'd0, 0);
    chk("bp.full", 64'(bus.count), 64'd4);
    chk("bp.head", 64'(bus.rd_o), 64'd1);
    cyc("bp.stall", 1, OP_R, 3'd0, 5'd9, 32'd9, 32'd0, 2'd0, 0);
    chk("bp.hold", 64'(bus.rd_o), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("bp.order", 64'(bus.rd_o), 64'(i));
      idle("bp.drain", 1);
    end
    chk("bp.empty", 64'(bus.wr_en), 64'd0);

    for (int i = 1; i <= 4; i++)
      cyc("full.fill", 1, OP_LG, 3'd0, 5'(i), 32'(i), 32'd0, 2'd0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc("full.pp", 1, OP_R, 3'd0, 5'(10 + i), 32'(100 + i),
          32'd0, 2'd0, 1);
      chk("full.pp.cnt", 64'(bus.count), 64'd4);
    end
    for (int i = 0; i < 4; i++) idle("full.drain", 1);

    for (int i = 0; i < 300; i++) begin
      cyc("rnd", 1'($urandom_range(0, 3) != 0),
          ops[$urandom_range(0, 8)], 3'($urandom),
          5'($urandom_range(0, 6)), 32'($urandom), 32'($urandom),
          2'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 5; i++) idle("rnd.drain", 1);

    for (int i = 1; i <= 3; i++)
      cyc("rst.fill", 1, OP_R, 3'd0, 5'(i + 20), 32'hA0 + 32'(i),
          32'd0, 2'd0, 0);
    rst_n = 1'b0;
    #1;
    q_rd.delete(); q_dat.delete();
    last_rd = 0; last_dat = 0;
`ifdef WBU_RETIRE_CNT_EN
    m_rc = 0;
`endif
    check_outs("rst.async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle("rst.after", 1);

`ifdef WBU_RETIRE_CNT_EN
    for (int i = 0; i < 7; i++)
      cyc("rc.acc", 1, (i % 3 == 1) ? OP_ST : OP_R, 3'd0,
          5'(i + 1), 32'(i), 32'd0, 2'd0, 1);
    chk("rc.seven", retire_cnt, 64'd7);
    retire_clr = 1'b1;
    cyc("rc.clr", 1, OP_R, 3'd0, 5'd7, 32'd7, 32'd0, 2'd0, 1);
    retire_clr = 1'b0;
    chk("rc.one", retire_cnt, 64'd1);
    idle("rc.idle", 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wbu_buf.md
Name: wbu_buf

Overview:
- Parametrised write-back unit with a small in-order write-back buffer, placed between the memory stage and the register-file write port.
- Per instruction it:
  - decides the register-file write enable from opcode and rd;
  - formats load data from funct3 and the address byte offset;
  - selects between the ALU result and the formatted load result;
  - queues the result until the shared write port accepts it (wb_ready).
- Generalises the single-cycle combinational write-back to XLEN, buffer depth, load extension and backpressure.

Parameters:
- XLEN, 32, data width of alu_out, load_out and rd_data.
- REG_AW, 5, register index width.
- DEPTH, 4, buffer entries; power of two, minimum 2.

Ports:
- clk input 1 system clock.
- rst_n input 1 asynchronous active-low reset.
- in_valid input 1 instruction presented by the memory stage.
- in_ready output 1 block can accept the presented instruction.
- opcode input 7 instruction opcode; compared against the `opcode_* macros in define.v.
- funct3 input 3 load size/sign selector.
- rd_i input REG_AW destination register.
- alu_out input XLEN ALU result; carries the link address for jal/jalr.
- load_out input XLEN raw aligned memory word.
- addr_lo input 2 byte offset of the load address.
- wb_ready input 1 register-file write port accepts this cycle.
- wr_en output 1 write request to the register file.
- rd_o output REG_AW write index.
- rd_data output XLEN write data.
- count output $clog2(DEPTH)+1 current buffer occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - read/write pointers and count = 0.
  - wr_en=0, rd_o=0, rd_data=0.
  - in_ready=1 once rst_n deasserts.
  - Any in-flight entries are discarded; no write is issued for them.
- Writing opcodes: `opcode_R, `opcode_I_lg, `opcode_I_ld, `opcode_U_lui, `opcode_U_auipc, `opcode_J_jal, `opcode_J_jalr.
- Accept condition: in_valid && in_ready.
- Enqueue on accept only when the opcode is a writing opcode and rd_i != 0.
  - Non-writing opcodes and rd_i==0 are accepted and dropped; count is unchanged.
- Data selection:
  - opcode==`opcode_I_ld: formatted load data.
  - All other writing opcodes: alu_out.
- Load formatting. Byte select = load_out[8*addr_lo +: 8]; half select = load_out[16*addr_lo[1] +: 16].
  - funct3 000 (LB): sign-extended byte.
  - funct3 100 (LBU): zero-extended byte.
  - funct3 001 (LH): sign-extended half.
  - funct3 101 (LHU): zero-extended half.
  - funct3 010 (LW): full word.
  - Other funct3 values: full word.
  - Misalignment is not checked here.
- Buffer: circular FIFO of DEPTH entries {rd, data}. Pointers wrap modulo DEPTH.
- Outputs are driven from the head entry:
  - wr_en = (count != 0).
  - rd_o and rd_data = head fields.
  - When count==0, rd_o and rd_data hold their last value.
- Pop when wr_en && wb_ready.
- Latency: an entry accepted in cycle N appears on wr_en/rd_o/rd_data in cycle N+1 at the earliest. There is no input-to-output combinational bypass.
- in_ready = (count < DEPTH) || (wr_en && wb_ready). This is a combinational dependence on wb_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, a same-cycle pop frees the slot for the push.
- Empty with a push: the entry is visible next cycle, not the same cycle.
- wb_ready held low: the head is held stable and wr_en stays high until accepted.
- Ordering is strictly in order. A later write to the same rd overwrites at the register file in program order.

Optional Feature:
- WBU_RETIRE_CNT_EN
  - Defined: adds output retire_cnt (64 bits) and input retire_clr (1 bit).
  - retire_cnt increments by 1 on every accept, including dropped non-writing instructions.
  - retire_cnt resets to 0 on rst_n and clears synchronously on retire_clr.
  - If retire_clr and an accept occur in the same cycle, the result is 1.
  - The counter wraps at 2^64.
  - Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: fill 3 entries, pulse rst_n low -> count=0, wr_en=0, rd_o=0, rd_data=0 asynchronously; no further writes.
- LB on load_out=0x80FF7F01 -> rd_data=0xFFFFFF80 (addr_lo=3), 0x0000007F (addr_lo=1); LHU with addr_lo=2 -> 0x000080FF; LW -> 0x80FF7F01.
- Drop cases: store opcode with rd_i=5, and R-type with rd_i=0 -> both accepted (in_ready=1), count stays 0, wr_en stays 0.
- Backpressure: wb_ready=0, push 4 R-type entries with rd 1..4 -> count=4, in_ready=0, wr_en=1 with rd_o=1 held stable; then wb_ready=1 -> rd 1..4 written on 4 consecutive cycles, in order.
- Full plus simultaneous pop and push (DEPTH=4, wb_ready=1, in_valid=1) -> in_ready=1, count stays 4, pointers wrap correctly over 10 cycles.
- With WBU_RETIRE_CNT_EN: 7 accepts (2 dropped) -> retire_cnt=7; retire_clr together with an accept -> retire_cnt=1.
